// File: rtl/pkt_pkg.sv
// Shared types, header layout and ECC helper for the packet builder.
package pkt_pkg;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned TYPE_W     = 4;
    localparam int unsigned ECC_W      = 4;
    localparam int unsigned SOP_W      = 3;
    localparam int unsigned HDR_W      = 16;
    localparam int unsigned MEM_DATA_W = 32;

    // Header field positions within the 16-bit header word
    localparam int unsigned HDR_ECC_LSB     = 0;
    localparam int unsigned HDR_CNT_LSB     = 4;
    localparam int unsigned HDR_TYPE_LSB    = 8;
    localparam int unsigned HDR_ECC_MSB_BIT = 12;
    localparam int unsigned HDR_SOP_LSB     = 13;

    // Payload byte 0 sits right after the two header bytes
    localparam int unsigned PAYLOAD_OFS = 2;

    localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_HDR_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC_WR  = 3'd4,
        ST_DONE    = 3'd5
    } pb_state_e;

    // Packet configuration captured on the start pulse
    typedef struct packed {
        logic [ADDR_W-1:0] addr_hdr;
        logic [CNT_W-1:0]  byte_cnt;
        logic [TYPE_W-1:0] pkt_type;
        logic              inj_single;
        logic              inj_double;
        logic              inj_crc;
    } pb_cfg_t;

    typedef struct packed {
        logic             msb;
        logic [ECC_W-1:0] ecc;
    } hdr_ecc_t;

    // Hamming-style check bits plus overall parity over {pkt_type, byte_cnt}
    function automatic hdr_ecc_t pkt_ecc(input logic [BYTE_W-1:0] d);
        hdr_ecc_t r;
        r.ecc[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        r.ecc[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        r.ecc[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        r.ecc[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        r.msb    = ^d;
        return r;
    endfunction

endpackage

// File: rtl/crc_chk_calc.sv
// One-byte CRC8 step shared by the packet generator and checker.
module crc_chk_calc
    import pkt_pkg::*;
(
    input  logic [BYTE_W-1:0] crc_in,
    input  logic [BYTE_W-1:0] data_in,
    output logic [BYTE_W-1:0] crc_out
);

    // MSB-first shift of the byte through the CRC8 polynomial
    always_comb begin
        logic [BYTE_W-1:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[BYTE_W-1]) begin
                c = {c[BYTE_W-2:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[BYTE_W-2:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/pkt_builder.sv
// Packet builder: writes an ECC-protected header, the streamed payload and
// a trailing CRC8 byte into byte-addressed memory, then pulses pb_irq.
module pkt_builder
    import pkt_pkg::*;
#(
    parameter logic [SOP_W-1:0] SOP = 3'b101
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pb_start,
    input  logic [ADDR_W-1:0]     pb_addr_hdr,
    input  logic [CNT_W-1:0]      pb_byte_cnt,
    input  logic [TYPE_W-1:0]     pb_pkt_type,
    input  logic                  pb_inj_ecc_single,
    input  logic                  pb_inj_ecc_double,
    input  logic                  pb_inj_crc_err,
    input  logic                  in_valid,
    input  logic [BYTE_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [MEM_DATA_W-1:0] mem_data_i,
    output logic                  pb_busy,
    output logic                  pb_irq
);

    pb_state_e         state_q, state_d;
    pb_cfg_t           cfg_q;
    logic [BYTE_W-1:0] crc_q;
    logic [BYTE_W-1:0] crc_next;
    logic [CNT_W-1:0]  idx_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              accept_c;
    logic [BYTE_W-1:0] mem_byte_c;
    logic [CNT_W-1:0]  wr_cnt_c;
    hdr_ecc_t          ecc_c;
    logic [HDR_W-1:0]  hdr_c;

    crc_chk_calc u_crc (
        .crc_in  (crc_q),
        .data_in (in_data),
        .crc_out (crc_next)
    );

    // Header word: ECC from the true byte_cnt, injection only on the written copy
    always_comb begin
        ecc_c = pkt_ecc({cfg_q.pkt_type, cfg_q.byte_cnt});
        if (cfg_q.inj_double) begin
            wr_cnt_c = cfg_q.byte_cnt ^ 4'b0011;
        end else if (cfg_q.inj_single) begin
            wr_cnt_c = cfg_q.byte_cnt ^ 4'b0001;
        end else begin
            wr_cnt_c = cfg_q.byte_cnt;
        end
        hdr_c                              = '0;
        hdr_c[HDR_ECC_LSB +: ECC_W]        = ecc_c.ecc;
        hdr_c[HDR_CNT_LSB +: CNT_W]        = wr_cnt_c;
        hdr_c[HDR_TYPE_LSB +: TYPE_W]      = cfg_q.pkt_type;
        hdr_c[HDR_ECC_MSB_BIT]             = ecc_c.msb;
        hdr_c[HDR_SOP_LSB +: SOP_W]        = SOP;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_byte_c = '0;
        pb_irq     = 1'b0;
        accept_c   = 1'b0;
        pb_busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pb_start) begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                mem_we     = 1'b1;
                mem_byte_c = hdr_c[7:0];
                state_d    = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                mem_we     = 1'b1;
                mem_byte_c = hdr_c[15:8];
                state_d    = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we     = 1'b1;
                    mem_byte_c = in_data;
                    accept_c   = 1'b1;
                    if (idx_q == cfg_q.byte_cnt) begin
                        state_d = ST_CRC_WR;
                    end
                end
            end
            ST_CRC_WR: begin
                mem_we     = 1'b1;
                mem_byte_c = cfg_q.inj_crc ? ~crc_q : crc_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                pb_irq  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Config latch, CRC accumulator, payload index and write address pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q      <= '0;
            crc_q      <= '0;
            idx_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pb_start) begin
                        cfg_q.addr_hdr   <= pb_addr_hdr;
                        cfg_q.byte_cnt   <= pb_byte_cnt;
                        cfg_q.pkt_type   <= pb_pkt_type;
                        cfg_q.inj_single <= pb_inj_ecc_single;
                        cfg_q.inj_double <= pb_inj_ecc_double;
                        cfg_q.inj_crc    <= pb_inj_crc_err;
                        crc_q            <= '0;
                        idx_q            <= '0;
                        mem_addr_q       <= pb_addr_hdr;
                    end
                end
                ST_HDR_LO: begin
                    mem_addr_q <= cfg_q.addr_hdr + ADDR_W'(1);
                end
                ST_HDR_HI: begin
                    mem_addr_q <= cfg_q.addr_hdr + ADDR_W'(PAYLOAD_OFS);
                end
                ST_PAYLOAD: begin
                    // After the last byte the pointer lands on addr_hdr+byte_cnt+3
                    if (accept_c) begin
                        crc_q      <= crc_next;
                        idx_q      <= idx_q + CNT_W'(1);
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data_i = {{(MEM_DATA_W-BYTE_W){1'b0}}, mem_byte_c};

endmodule

// File: tb/tb_pkt_builder.sv
// Self-checking bench for pkt_builder: vector table plus scoreboard of memory writes.
module tb_pkt_builder;

    logic        clk = 1'b0;
    logic        reset;
    logic        pb_start;
    logic [13:0] pb_addr_hdr;
    logic [3:0]  pb_byte_cnt;
    logic [3:0]  pb_pkt_type;
    logic        pb_inj_ecc_single;
    logic        pb_inj_ecc_double;
    logic        pb_inj_crc_err;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_data_i;
    logic        pb_busy;
    logic        pb_irq;

    pkt_builder #(.SOP(3'b101)) dut (
        .clk               (clk),
        .reset             (reset),
        .pb_start          (pb_start),
        .pb_addr_hdr       (pb_addr_hdr),
        .pb_byte_cnt       (pb_byte_cnt),
        .pb_pkt_type       (pb_pkt_type),
        .pb_inj_ecc_single (pb_inj_ecc_single),
        .pb_inj_ecc_double (pb_inj_ecc_double),
        .pb_inj_crc_err    (pb_inj_crc_err),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .mem_addr          (mem_addr),
        .mem_we            (mem_we),
        .mem_data_i        (mem_data_i),
        .pb_busy           (pb_busy),
        .pb_irq            (pb_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];
    int  iq[$];

    typedef struct {
        logic [13:0] addr;
        logic [3:0]  cnt;
        logic [3:0]  ptype;
        logic        inj_s;
        logic        inj_d;
        logic        inj_c;
        logic        hold_start;
        int          gpos;
        int          glen;
        logic [7:0]  exp_h0;
        logic [7:0]  exp_h1;
        logic        crc_fix_en;
        logic [7:0]  crc_fix;
    } vec_t;

    // Bit-serial CRC8 (poly 0x07, MSB first, no reflection)
    function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Scoreboard: every write and every irq pulse must match the next expectation
    always @(negedge clk) begin
        #2;
        if (mem_we === 1'b1) begin
            nvec++;
            if (wq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, mem_addr, mem_data_i);
            end else begin
                wr_t e;
                e = wq.pop_front();
                if (mem_addr !== e.addr || mem_data_i !== e.data || cyc != e.cyc) begin
                    nerr++;
                    $display("FAIL mem_write got cyc=%0d addr=%h data=%h exp cyc=%0d addr=%h data=%h",
                             cyc, mem_addr, mem_data_i, e.cyc, e.addr, e.data);
                end
            end
        end
        if (pb_irq === 1'b1) begin
            nvec++;
            if (iq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_irq cyc=%0d", cyc);
            end else begin
                int ec;
                ec = iq.pop_front();
                if (cyc != ec) begin
                    nerr++;
                    $display("FAIL irq_cycle got=%0d exp=%0d", cyc, ec);
                end
            end
        end
    end

    task automatic run_pkt(input vec_t v);
        logic [7:0] pl [16];
        logic [7:0] crc;
        int         n, idx, gc, budget, last;
        logic       acc;
        bit         done_seen;
        pl[0] = 8'h55;
        for (int k = 1; k < 16; k++) pl[k] = 8'($urandom);
        last = int'(v.cnt);
        crc  = 8'h00;
        for (int k = 0; k <= last; k++) crc = crc_model(crc, pl[k]);
        if (v.crc_fix_en) crc = v.crc_fix;
        else if (v.inj_c) crc = ~crc;

        @(negedge clk);
        n                 = cyc;
        pb_start          = 1'b1;
        pb_addr_hdr       = v.addr;
        pb_byte_cnt       = v.cnt;
        pb_pkt_type       = v.ptype;
        pb_inj_ecc_single = v.inj_s;
        pb_inj_ecc_double = v.inj_d;
        pb_inj_crc_err    = v.inj_c;
        in_valid          = 1'b0;

        wq.push_back('{n + 1, v.addr, {24'h0, v.exp_h0}});
        wq.push_back('{n + 2, 14'(v.addr + 14'd1), {24'h0, v.exp_h1}});
        for (int k = 0; k <= last; k++) begin
            wq.push_back('{n + 3 + k + ((k >= v.gpos) ? v.glen : 0),
                           14'(v.addr + 14'd2 + 14'(k)), {24'h0, pl[k]}});
        end
        wq.push_back('{n + 4 + last + v.glen, 14'(v.addr + 14'(last) + 14'd3), {24'h0, crc}});
        iq.push_back(n + 5 + last + v.glen);

        idx = 0; gc = 0; budget = 0; done_seen = 0;
        while (!done_seen && budget < 80) begin
            @(negedge clk);
            budget++;
            pb_start = v.hold_start;
            if (idx <= last) begin
                if (in_ready && idx == v.gpos && gc < v.glen) begin
                    in_valid = 1'b0;
                    gc++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = pl[idx];
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            if (pb_irq === 1'b1) done_seen = 1;
            if (acc) idx++;
        end
        if (!done_seen) begin
            nvec++;
            nerr++;
            $display("FAIL pkt_timeout got=no_irq exp=irq addr=%h", v.addr);
        end
        @(negedge clk);
        pb_start = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("busy_after_pkt", 32'(pb_busy), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t vt [9];
        vec_t ab;
        int   n;
        logic [7:0] apl [3];

        //        addr     cnt   type  s  d  c  hold gpos glen h0     h1     fix  crc
        vt[0] = '{14'h010, 4'h0, 4'hA, 0, 0, 0, 0,   0,   0,   8'h06, 8'hAA, 1,   8'hAC};
        vt[1] = '{14'h010, 4'h0, 4'hA, 1, 0, 0, 0,   0,   0,   8'h16, 8'hAA, 1,   8'hAC};
        vt[2] = '{14'h010, 4'h0, 4'hA, 0, 1, 0, 0,   0,   0,   8'h36, 8'hAA, 1,   8'hAC};
        vt[3] = '{14'h010, 4'h0, 4'hA, 1, 1, 0, 0,   0,   0,   8'h36, 8'hAA, 1,   8'hAC};
        vt[4] = '{14'h010, 4'h0, 4'hA, 0, 0, 1, 0,   0,   0,   8'h06, 8'hAA, 1,   8'h53};
        vt[5] = '{14'h3FFE, 4'h1, 4'h3, 0, 0, 0, 1,  0,   0,   8'h10, 8'hB3, 0,   8'h00};
        vt[6] = '{14'h100, 4'h3, 4'h5, 0, 0, 0, 0,   2,   3,   8'h34, 8'hA5, 0,   8'h00};
        vt[7] = '{14'h2000, 4'hF, 4'hF, 0, 0, 0, 0,  0,   0,   8'hF3, 8'hAF, 0,   8'h00};
        vt[8] = '{14'h2000, 4'hF, 4'hF, 0, 1, 0, 0,  0,   0,   8'hC3, 8'hAF, 0,   8'h00};

        reset = 1'b1; pb_start = 1'b0; pb_addr_hdr = '0; pb_byte_cnt = '0;
        pb_pkt_type = '0; pb_inj_ecc_single = 1'b0; pb_inj_ecc_double = 1'b0;
        pb_inj_crc_err = 1'b0; in_valid = 1'b0; in_data = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_data", mem_data_i, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(pb_busy), 32'd0);
        chk("rst_irq", 32'(pb_irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_pkt(vt[i]);

        // Reset in PAYLOAD after three accepted bytes aborts the packet
        apl[0] = 8'h11; apl[1] = 8'h22; apl[2] = 8'h33;
        @(negedge clk);
        n = cyc;
        pb_start = 1'b1; pb_addr_hdr = 14'h200; pb_byte_cnt = 4'h7; pb_pkt_type = 4'h5;
        pb_inj_ecc_single = 1'b0; pb_inj_ecc_double = 1'b0; pb_inj_crc_err = 1'b0;
        wq.push_back('{n + 1, 14'h200, 32'h72});
        wq.push_back('{n + 2, 14'h201, 32'hB5});
        for (int k = 0; k < 3; k++) wq.push_back('{n + 3 + k, 14'(14'h202 + 14'(k)), {24'h0, apl[k]}});
        @(negedge clk); pb_start = 1'b0; in_valid = 1'b1; in_data = apl[0];
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); in_data = apl[1];
        @(negedge clk); in_data = apl[2]; reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_busy", 32'(pb_busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_writes", 32'(wq.size()), 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_idle_busy", 32'(pb_busy), 32'd0);

        ab = vt[0];
        run_pkt(ab);
        run_pkt(vt[6]);

        repeat (4) @(negedge clk);
        #1;
        chk("final_irq_queue", 32'(iq.size()), 32'd0);
        chk("final_wr_queue", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
